keypad_scan_debounce: RTL and testbench

//  Upstream stage of the divider datapath: drives a 4x4 matrix keypad column by column,

---
 rtl/keypad_scan_debounce.sv | 184 ++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Drives a 4x4 matrix keypad one column at a time and synchronises the row
//   lines. It debounces both the press and the release, and emits one hex
//   code for each physical key press.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   fil[3:0]   keypad rows, active-low (4'hF = nothing pressed)
//   col[3:0]   keypad column drive, one-hot active-low
//   key_code   hex code of the last accepted key, held until the next press
//   key_valid  one-cycle pulse, key_code is valid in the same cycle
//   key_held   high from key_valid until the release debounce completes
module keypad_scan_debounce #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEB_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_col;
  logic [3:0]        r_row_pat;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_held;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DEB_W-1:0]  r_deb_cnt;

  logic       w_one_low;
  logic [1:0] w_row_idx;
  logic [1:0] w_col_idx;
  logic [3:0] w_code;
  logic [3:0] w_col_rot;

  // Two-flop synchroniser. It idles at all-high so that reset looks like "no key".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= fil;
      r_sync2 <= r_sync1;
    end
  end

  // A press counts only when exactly one row is low.
  // Two or more low rows mean ghosting, and the sample is discarded.
  assign w_one_low = ($countones(~r_sync2) == 1);

  assign w_col_rot = {r_col[2:0], r_col[3]};

  always_comb begin
    w_row_idx = 2'd0;
    if (!r_row_pat[1])      w_row_idx = 2'd1;
    else if (!r_row_pat[2]) w_row_idx = 2'd2;
    else if (!r_row_pat[3]) w_row_idx = 2'd3;
  end

  always_comb begin
    unique case (r_col)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Keypad legend: row 3 carries the * and # keys, which are coded E and F.
  always_comb begin
    unique case ({w_row_idx, w_col_idx})
      4'h0: w_code = 4'h1;
      4'h1: w_code = 4'h2;
      4'h2: w_code = 4'h3;
      4'h3: w_code = 4'hA;
      4'h4: w_code = 4'h4;
      4'h5: w_code = 4'h5;
      4'h6: w_code = 4'h6;
      4'h7: w_code = 4'hB;
      4'h8: w_code = 4'h7;
      4'h9: w_code = 4'h8;
      4'hA: w_code = 4'h9;
      4'hB: w_code = 4'hC;
      4'hC: w_code = 4'hE;
      4'hD: w_code = 4'h0;
      4'hE: w_code = 4'hF;
      default: w_code = 4'hD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_SCAN;
      r_col       <= 4'b1110;
      r_row_pat   <= 4'hF;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
    end else begin
      r_key_valid <= 1'b0;
      unique case (r_state)
        // Rows are sampled only at the end of a column's dwell time.
        // By then the synchroniser has seen the newly driven column.
        S_SCAN: begin
          if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            if (w_one_low) begin
              r_row_pat <= r_sync2;
              r_deb_cnt <= '0;
              r_state   <= S_DEBOUNCE;
            end else begin
              r_col <= w_col_rot;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        // The column stays frozen. Any deviation from the latched pattern
        // restarts the dwell on the same column.
        S_DEBOUNCE: begin
          if (r_sync2 == r_row_pat) begin
            if (r_deb_cnt == DEB_LAST) r_state <= S_PRESSED;
            else                       r_deb_cnt <= r_deb_cnt + 1'b1;
          end else begin
            r_scan_cnt <= '0;
            r_state    <= S_SCAN;
          end
        end
        S_PRESSED: begin
          r_key_code  <= w_code;
          r_key_valid <= 1'b1;
          r_key_held  <= 1'b1;
          r_deb_cnt   <= '0;
          r_state     <= S_RELEASE;
        end
        // Wait for all rows high for the full debounce time.
        // A second key held meanwhile keeps the count in reset.
        S_RELEASE: begin
          if (r_sync2 == 4'hF) begin
            if (r_deb_cnt == DEB_LAST) begin
              r_key_held <= 1'b0;
              r_scan_cnt <= '0;
              r_col      <= w_col_rot;
              r_state    <= S_SCAN;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end else begin
            r_deb_cnt <= '0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce.
// A keypad model connects the driven column to the rows of the pressed keys.
// A reference model predicts the outputs from timestamps and run lengths:
//   - when a column's dwell ends,
//   - how long a row pattern has stayed stable,
//   - how long all rows have stayed high.
// The outputs are compared against that model on every cycle.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  localparam int PH_SCAN    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_EMIT    = 2;
  localparam int PH_HELD    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  fil;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press = 16'h0;   // bit r*4+c set = key at row r, column c held down

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  int n_pass  = 0;
  int n_total = 0;

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .fil       (fil),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column line to its row line.
  always_comb begin
    fil = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && (col[c] == 1'b0)) fil[r] = 1'b0;
  end

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         t_col = 0;
  int         t_ent = 0;
  int         t_rel = 0;
  int         m_c = 0;
  int         m_phase = PH_SCAN;
  int         m_row = 0;
  int         m_pulses = 0;
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  logic [3:0] m_fs = 4'hF;
  logic [3:0] m_pat = 4'hF;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_c = 0; m_phase = PH_SCAN; t_col = cyc;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_pat = 4'hF;
    end else begin
      cyc++;
      m_fs    = m_s2;
      m_valid = 1'b0;
      case (m_phase)
        PH_SCAN:
          if (cyc - t_col == SCAN_DIV) begin
            if ($countones(~m_fs) == 1) begin
              m_pat = m_fs; m_phase = PH_CONFIRM; t_ent = cyc;
            end else begin
              m_c = (m_c + 1) % 4; t_col = cyc;
            end
          end
        PH_CONFIRM:
          if (m_fs != m_pat) begin
            m_phase = PH_SCAN; t_col = cyc;
          end else if (cyc - t_ent == DEB) begin
            m_phase = PH_EMIT;
          end
        PH_EMIT: begin
          for (int r = 0; r < 4; r++) if (!m_pat[r]) m_row = r;
          m_code = keymap[m_row*4 + m_c];
          m_valid = 1'b1; m_held = 1'b1; m_pulses++;
          m_phase = PH_HELD; t_rel = cyc;
        end
        default:
          if (m_fs != 4'hF) t_rel = cyc;
          else if (cyc - t_rel == DEB) begin
            m_held = 1'b0; m_c = (m_c + 1) % 4; t_col = cyc; m_phase = PH_SCAN;
          end
      endcase
      m_s2 = m_s1;
      m_s1 = fil;
    end
  end

  // ---------------- per-cycle compare ----------------
  int         d_pulses = 0;
  logic [3:0] d_codes [$];
  logic [3:0] exp_col;

  initial forever begin
    @(negedge clk);
    exp_col = 4'hF ^ (4'h1 << m_c);
    chk4("col", col, exp_col);
    chk4("key_code", key_code, m_code);
    chk4("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    chk4("key_held", {3'b0, key_held}, {3'b0, m_held});
    if (key_valid === 1'b1) begin
      d_pulses++;
      d_codes.push_back(key_code);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && !(m_phase == PH_SCAN && !m_held); i++) step(1);
    chki(name, int'(m_phase == PH_SCAN && !m_held), 1);
    step(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk4({tag, "_col"},   col, 4'b1110);
    chk4({tag, "_code"},  key_code, 4'h0);
    chk4({tag, "_valid"}, {3'b0, key_valid}, 4'h0);
    chk4({tag, "_held"},  {3'b0, key_held}, 4'h0);
  endtask

  int         d0, m0, q0, k, hold, nb;
  logic [3:0] rot_exp;

  initial begin
    rst = 1'b0; press = 16'h0;
    step(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      rot_exp = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : 4'b1011;
      chk4($sformatf("rotate_%0d", i), col, rot_exp);
    end
    $display("txn reset/rotate done");

    // Clean press: row 1, column 2 -> '6'.
    d0 = d_pulses; m0 = m_pulses; q0 = d_codes.size();
    press[6] = 1'b1; step(40);
    press = 16'h0;
    step(9);  chki("clean_held_before", int'(key_held), 1);
    step(1);  chki("clean_held_after", int'(key_held), 0);
    wait_idle("clean_idle", 40);
    chki("clean_pulses", d_pulses - d0, 1);
    chki("clean_model_pulses", m_pulses - m0, 1);
    if (d_codes.size() > q0) chk4("clean_code", d_codes[q0], 4'h6);
    $display("txn clean r1c2 pulses %0d", d_pulses - d0);

    // Bouncing press: row 3, column 1 -> '0'.
    d0 = d_pulses; m0 = m_pulses; q0 = d_codes.size();
    for (int i = 0; i < 10; i++) begin press[13] = ~press[13]; step(3); end
    press[13] = 1'b1; step(50);
    press = 16'h0;
    wait_idle("bounce_idle", 40);
    chki("bounce_pulses", d_pulses - d0, 1);
    chki("bounce_model_pulses", m_pulses - m0, 1);
    if (d_codes.size() > q0) chk4("bounce_code", d_codes[q0], 4'h0);
    $display("txn bounce r3c1 pulses %0d", d_pulses - d0);

    // Glitch: too short to be accepted.
    d0 = d_pulses; m0 = m_pulses;
    press[0] = 1'b1; step(5); press = 16'h0; step(30);
    chki("glitch_pulses", d_pulses - d0, 0);
    chki("glitch_model_pulses", m_pulses - m0, 0);
    $display("txn glitch r0c0 pulses %0d", d_pulses - d0);

    // Ghost: two rows on the same column.
    d0 = d_pulses; m0 = m_pulses;
    press[1] = 1'b1; press[9] = 1'b1; step(40); press = 16'h0; step(10);
    chki("ghost_pulses", d_pulses - d0, 0);
    chki("ghost_model_pulses", m_pulses - m0, 0);
    $display("txn ghost r0c1+r2c1 pulses %0d", d_pulses - d0);

    // Sequence 1,2,3,4.
    d0 = d_pulses; q0 = d_codes.size();
    foreach (keymap[i]) begin
      if (i == 0 || i == 1 || i == 2 || i == 4) begin
        press = 16'h0; press[i] = 1'b1; step(40);
        press = 16'h0;
        wait_idle($sformatf("seq_idle_%0d", i), 40);
      end
    end
    chki("seq_pulses", d_pulses - d0, 4);
    if (d_codes.size() >= q0 + 4) begin
      chk4("seq_code0", d_codes[q0],   4'h1);
      chk4("seq_code1", d_codes[q0+1], 4'h2);
      chk4("seq_code2", d_codes[q0+2], 4'h3);
      chk4("seq_code3", d_codes[q0+3], 4'h4);
    end
    $display("txn sequence 1234 pulses %0d", d_pulses - d0);

    // Reset while debouncing a press.
    d0 = d_pulses;
    press[6] = 1'b1;
    for (int i = 0; i < 40 && m_phase != PH_CONFIRM; i++) step(1);
    chki("middeb_reached", m_phase, PH_CONFIRM);
    rst = 1'b0; step(2);
    check_reset_outputs("middeb");
    press = 16'h0; rst = 1'b1; step(40);
    chki("middeb_pulses", d_pulses - d0, 0);
    $display("txn reset mid-debounce pulses %0d", d_pulses - d0);

    // Reset while waiting for release.
    d0 = d_pulses;
    press[6] = 1'b1;
    for (int i = 0; i < 60 && !m_held; i++) step(1);
    chki("midrel_reached", int'(m_held), 1);
    step(2);
    rst = 1'b0; step(2);
    check_reset_outputs("midrel");
    press = 16'h0; rst = 1'b1; step(40);
    chki("midrel_pulses", d_pulses - d0, 1);
    $display("txn reset mid-release pulses %0d", d_pulses - d0);

    // Randomised presses with bounce at both edges.
    for (int t = 0; t < 12; t++) begin
      k    = $urandom_range(0, 15);
      hold = $urandom_range(36, 60);
      nb   = $urandom_range(0, 4);
      d0 = d_pulses; m0 = m_pulses; q0 = d_codes.size();
      repeat (nb) begin press[k] = ~press[k]; step($urandom_range(1, 3)); end
      press = 16'h0; press[k] = 1'b1; step(hold);
      repeat (nb) begin press[k] = ~press[k]; step($urandom_range(1, 3)); end
      press = 16'h0;
      wait_idle($sformatf("rand%0d_idle", t), 60);
      chki($sformatf("rand%0d_pulses", t), d_pulses - d0, 1);
      chki($sformatf("rand%0d_model_pulses", t), m_pulses - m0, 1);
      if (d_codes.size() > q0) chk4($sformatf("rand%0d_code", t), d_codes[q0], keymap[k]);
      $display("txn rand %0d key r%0dc%0d hold %0d bounces %0d pulses %0d",
               t, k / 4, k % 4, hold, nb, d_pulses - d0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
